// File: rtl/flex_rx_fifo.sv
// First-word-fall-through receive FIFO with occupancy count, threshold flags,
// sticky overflow/underflow and a synchronous flush. All outputs decode registered state.
module flex_rx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AF_THRESH  = 6,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         clear,
    input  logic                         w_enable,
    input  logic [DATA_WIDTH-1:0]        w_data,
    input  logic                         r_enable,
    output logic [DATA_WIDTH-1:0]        r_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_empty,
    output logic                         almost_full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wptr_q, wptr_d;
    logic [PtrW-1:0]       rptr_q, rptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic is_empty, is_full, do_write, do_read;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CntW'(DEPTH));
    assign do_read  = r_enable && !is_empty;
    // When full, a simultaneous pop frees the slot this write lands in.
    assign do_write = w_enable && (!is_full || r_enable);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (do_write) wptr_d = ptr_inc(wptr_q);
            if (do_read)  rptr_d = ptr_inc(rptr_q);
            case ({do_write, do_read})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (w_enable && is_full && !r_enable) ovf_d = 1'b1;
            if (r_enable && is_empty)             udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is not reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_write && !clear) mem_q[wptr_q] <= w_data;
    end

    always_comb begin
        r_data       = is_empty ? '0 : mem_q[rptr_q];
        count        = count_q;
        empty        = is_empty;
        full         = is_full;
        almost_empty = (count_q <= CntW'(AE_THRESH));
        almost_full  = (count_q >= CntW'(AF_THRESH));
        overflow     = ovf_q;
        underflow    = udf_q;
    end

endmodule

// File: tb/tb_flex_rx_fifo.sv
// Directed bench for flex_rx_fifo: an 8-deep instance for most scenarios and a
// 5-deep instance for pointer wrap-around.
module tb_flex_rx_fifo;

    logic clk, n_rst;

    logic       clr8, w_en8, r_en8;
    logic [7:0] wd8, rd8;
    logic [3:0] cnt8;
    logic       emp8, ful8, ae8, af8, ov8, un8;

    logic       clr5, w_en5, r_en5;
    logic [7:0] wd5, rd5;
    logic [2:0] cnt5;
    logic       emp5, ful5, ae5, af5, ov5, un5;

    logic [9:0] st8;
    assign st8 = {cnt8, emp8, ful8, ae8, af8, ov8, un8};

    int checks = 0;
    int errors = 0;

    logic [7:0] pat [8] = '{8'h00, 8'hFF, 8'h00, 8'h0F, 8'hF0, 8'hFF, 8'hFF, 8'h00};

    flex_rx_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) u_dut (
        .clk(clk), .n_rst(n_rst), .clear(clr8), .w_enable(w_en8), .w_data(wd8),
        .r_enable(r_en8), .r_data(rd8), .count(cnt8), .empty(emp8), .full(ful8),
        .almost_empty(ae8), .almost_full(af8), .overflow(ov8), .underflow(un8)
    );

    flex_rx_fifo #(.DATA_WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_dut5 (
        .clk(clk), .n_rst(n_rst), .clear(clr5), .w_enable(w_en5), .w_data(wd5),
        .r_enable(r_en5), .r_data(rd5), .count(cnt5), .empty(emp5), .full(ful5),
        .almost_empty(ae5), .almost_full(af5), .overflow(ov5), .underflow(un5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clr8 = 1'b1;
        step();
        clr8 = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #3;
        checks++;
        if (st8 !== 10'b0000_1_0_1_0_0_0) begin
            errors++;
            $display("FAIL reset_status: got %b expected %b", st8, 10'b0000_1_0_1_0_0_0);
        end
        checks++;
        if (rd8 !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 00", rd8);
        end
        checks++;
        if ({cnt5, emp5, ov5, un5} !== 6'b000_1_0_0) begin
            errors++;
            $display("FAIL reset_dut5: got %b expected 000100", {cnt5, emp5, ov5, un5});
        end
        @(negedge clk);
        n_rst = 1'b1;
        step();
    endtask

    task automatic test_fill();
        logic [9:0] exp;
        for (int i = 0; i < 8; i++) begin
            w_en8 = 1'b1;
            wd8   = pat[i];
            step();
            exp = {4'(i + 1), 1'b0, (i + 1) == 8, (i + 1) <= 2, (i + 1) >= 6, 2'b00};
            checks++;
            if (st8 !== exp) begin
                errors++;
                $display("FAIL fill_status[%0d]: got %b expected %b", i, st8, exp);
            end
            checks++;
            if (rd8 !== 8'h00) begin
                errors++;
                $display("FAIL fill_head[%0d]: got %h expected 00", i, rd8);
            end
        end
        w_en8 = 1'b0;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd8 !== pat[i]) begin
                errors++;
                $display("FAIL drain_data[%0d]: got %h expected %h", i, rd8, pat[i]);
            end
            r_en8 = 1'b1;
            step();
            checks++;
            if (cnt8 !== 4'(7 - i)) begin
                errors++;
                $display("FAIL drain_count[%0d]: got %0d expected %0d", i, cnt8, 7 - i);
            end
        end
        r_en8 = 1'b0;
        checks++;
        if ({emp8, ful8, ae8, af8, rd8} !== {4'b1010, 8'h00}) begin
            errors++;
            $display("FAIL drain_empty: got %b/%h expected 1010/00", {emp8, ful8, ae8, af8}, rd8);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) begin
            w_en8 = 1'b1;
            wd8   = pat[i];
            step();
        end
        wd8 = 8'hAA;
        step();
        w_en8 = 1'b0;
        checks++;
        if (st8 !== 10'b1000_0_1_0_1_1_0) begin
            errors++;
            $display("FAIL ovf_status: got %b expected %b", st8, 10'b1000_0_1_0_1_1_0);
        end
        checks++;
        if (rd8 !== 8'h00) begin
            errors++;
            $display("FAIL ovf_head: got %h expected 00", rd8);
        end
        w_en8 = 1'b1;
        r_en8 = 1'b1;
        wd8   = 8'hAA;
        step();
        w_en8 = 1'b0;
        r_en8 = 1'b0;
        checks++;
        if ({cnt8, ov8, rd8} !== {4'd8, 1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL full_rw: got cnt=%0d ovf=%b head=%h expected 8 1 ff", cnt8, ov8, rd8);
        end
        for (int i = 0; i < 8; i++) begin
            exp = (i < 7) ? pat[i + 1] : 8'hAA;
            checks++;
            if (rd8 !== exp) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: got %h expected %h", i, rd8, exp);
            end
            r_en8 = 1'b1;
            step();
        end
        r_en8 = 1'b0;
        pulse_clear();
        checks++;
        if ({emp8, ov8, un8} !== 3'b100) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 100", {emp8, ov8, un8});
        end
    endtask

    task automatic test_underflow();
        r_en8 = 1'b1;
        step();
        r_en8 = 1'b0;
        checks++;
        if (st8 !== 10'b0000_1_0_1_0_0_1) begin
            errors++;
            $display("FAIL udf_status: got %b expected %b", st8, 10'b0000_1_0_1_0_0_1);
        end
        w_en8 = 1'b1;
        r_en8 = 1'b1;
        wd8   = 8'h5A;
        step();
        w_en8 = 1'b0;
        r_en8 = 1'b0;
        checks++;
        if ({cnt8, emp8, un8, rd8} !== {4'd1, 1'b0, 1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL empty_rw: got cnt=%0d emp=%b udf=%b rd=%h expected 1 0 1 5a",
                     cnt8, emp8, un8, rd8);
        end
        r_en8 = 1'b1;
        step();
        r_en8 = 1'b0;
        pulse_clear();
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 3; k++) begin
            w_en5 = 1'b1;
            wd5   = 8'(k);
            step();
        end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (rd5 !== 8'(k)) begin
                errors++;
                $display("FAIL wrap_data[%0d]: got %h expected %h", k, rd5, 8'(k));
            end
            w_en5 = 1'b1;
            r_en5 = 1'b1;
            wd5   = 8'(k + 3);
            step();
            checks++;
            if (cnt5 !== 3'd3) begin
                errors++;
                $display("FAIL wrap_count[%0d]: got %0d expected 3", k, cnt5);
            end
        end
        r_en5 = 1'b0;
        for (int k = 15; k < 18; k++) begin
            wd5 = 8'(k);
            step();
        end
        w_en5 = 1'b0;
        checks++;
        if ({cnt5, ful5, ov5, af5} !== {3'd5, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL wrap_full: got cnt=%0d full=%b ovf=%b af=%b expected 5 1 1 1",
                     cnt5, ful5, ov5, af5);
        end
        for (int k = 12; k < 17; k++) begin
            checks++;
            if (rd5 !== 8'(k)) begin
                errors++;
                $display("FAIL wrap_drain[%0d]: got %h expected %h", k, rd5, 8'(k));
            end
            r_en5 = 1'b1;
            step();
        end
        r_en5 = 1'b0;
        checks++;
        if ({emp5, cnt5} !== 4'b1_000) begin
            errors++;
            $display("FAIL wrap_empty: got %b expected 1000", {emp5, cnt5});
        end
    endtask

    task automatic test_clear();
        r_en8 = 1'b1;
        step();
        r_en8 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_en8 = 1'b1;
            wd8   = 8'(k);
            step();
        end
        checks++;
        if ({cnt8, un8} !== {4'd4, 1'b1}) begin
            errors++;
            $display("FAIL preclear: got cnt=%0d udf=%b expected 4 1", cnt8, un8);
        end
        clr8 = 1'b1;
        wd8  = 8'h77;
        step();
        clr8  = 1'b0;
        w_en8 = 1'b0;
        checks++;
        if ({st8, rd8} !== {10'b0000_1_0_1_0_0_0, 8'h00}) begin
            errors++;
            $display("FAIL clear_status: got %b/%h expected 0000101000/00", st8, rd8);
        end
        step();
        checks++;
        if ({cnt8, emp8} !== 5'b0000_1) begin
            errors++;
            $display("FAIL clear_discard: got %b expected 00001", {cnt8, emp8});
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            w_en8 = 1'b1;
            wd8   = 8'h10 + 8'(k);
            step();
        end
        #2;
        n_rst = 1'b0;
        #1;
        checks++;
        if ({st8, rd8} !== {10'b0000_1_0_1_0_0_0, 8'h00}) begin
            errors++;
            $display("FAIL async_reset: got %b/%h expected 0000101000/00", st8, rd8);
        end
        step();
        checks++;
        if (cnt8 !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: got %0d expected 0", cnt8);
        end
        w_en8 = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        w_en8 = 1'b1;
        wd8   = 8'h3C;
        step();
        w_en8 = 1'b0;
        checks++;
        if ({cnt8, rd8} !== {4'd1, 8'h3C}) begin
            errors++;
            $display("FAIL post_reset_push: got cnt=%0d rd=%h expected 1 3c", cnt8, rd8);
        end
    endtask

    initial begin
        n_rst = 1'b0;
        clr8 = 1'b0; w_en8 = 1'b0; r_en8 = 1'b0; wd8 = 8'h00;
        clr5 = 1'b0; w_en5 = 1'b0; r_en5 = 1'b0; wd5 = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_overflow();
        test_underflow();
        test_wrap();
        test_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
